main_memory_responder: RTL and testbench



---
 rtl/main_memory_responder.sv | 123 ++++++++++++
 tb/tb_main_memory_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_responder.sv
// main_memory_responder: word-addressed synchronous main memory with a
// boot-load phase. After reset a program image streams in over a
// valid/ready port (S_LOAD); once the last beat lands, mem_ready rises and
// the CPU read/write port goes live (S_RUN). Reads are registered (1-cycle
// latency); out-of-range CPU writes are dropped and raise a sticky fault.
// Optional feature: define MAIN_MEMORY_FORWARD_EN for write-first
// same-index read-during-write. When it is undefined, the read is read-first.
module main_memory_responder #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] read_address,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    output logic [31:0] read_data,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        mem_ready,
    output logic        fault
);

    localparam int IW = $clog2(DEPTH_WORDS);

    localparam logic [0:0] S_LOAD = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] load_ptr_q, load_ptr_d;
    logic [31:0]   read_data_q, read_data_d;
    logic          fault_q, fault_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          mem_we;
    logic [IW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    logic [IW-1:0] rd_idx, wr_idx;
    logic          rd_in_range, wr_in_range;

    assign rd_idx      = read_address[IW-1:0];
    assign wr_idx      = write_address[IW-1:0];
    assign rd_in_range = (read_address[31:IW] == '0);
    assign wr_in_range = (write_address[31:IW] == '0);

    // Handshake and status are purely combinational on state and reset.
    assign load_ready = (state_q == S_LOAD) && !rst;
    assign mem_ready  = (state_q == S_RUN);
    assign read_data  = read_data_q;
    assign fault      = fault_q;

    // Next-state, memory write port and read result selection.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d     = state_q;
        load_ptr_d  = load_ptr_q;
        read_data_d = '0;
        fault_d     = fault_q;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;

        if (state_q == S_LOAD) begin
            // The CPU port is inert while loading; read_data stays 0.
            if (load_valid && load_ready) begin
                mem_we     = 1'b1;
                mem_waddr  = load_ptr_q;
                mem_wdata  = load_data;
                load_ptr_d = load_ptr_q + 1'b1;
                if (load_last || (load_ptr_q == IW'(DEPTH_WORDS - 1))) begin
                    state_d = S_RUN;
                end
            end
        end else begin
            if (rd_in_range) begin
                read_data_d = mem[rd_idx];
            end
            if (write_enable) begin
                if (wr_in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_idx;
                    mem_wdata = write_data;
`ifdef MAIN_MEMORY_FORWARD_EN
                    if (rd_in_range && (rd_idx == wr_idx)) begin
                        read_data_d = write_data;
                    end
`endif
                end else begin
                    fault_d = 1'b1;
                end
            end
        end
    end

    // Control and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q     <= S_LOAD;
            load_ptr_q  <= '0;
            read_data_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_ptr_q  <= load_ptr_d;
            read_data_q <= read_data_d;
            fault_q     <= fault_d;
        end
    end

    // Storage array; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        // NOTE: the memory array is deliberately not reset; contents survive rst.
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder (DEPTH_WORDS = 256).
// Expected read data is pushed to a scoreboard queue when a CPU cycle is
// driven, and popped and compared after the edge that produces read_data.
module tb_main_memory_responder;

    localparam int DEPTH = 256;

    logic        clk;
    logic        rst;
    logic [31:0] read_address;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] read_data;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        mem_ready;
    logic        fault;

    main_memory_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .read_address  (read_address),
        .write_address (write_address),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .read_data     (read_data),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_last     (load_last),
        .load_ready    (load_ready),
        .mem_ready     (mem_ready),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model of the responder.
    logic [31:0] model_mem [DEPTH];
    bit          model_run;
    int          model_ptr;
    bit          model_fault;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return a < 32'(DEPTH);
    endfunction

    task automatic idle_inputs();
        write_enable = 1'b0;
        load_valid   = 1'b0;
        load_last    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        check("load_ready_in_rst", {31'b0, load_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        model_run   = 1'b0;
        model_ptr   = 0;
        model_fault = 1'b0;
        #1;
        check("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        check("rst_load_ready", {31'b0, load_ready}, 32'd1);
    endtask

    // One load beat offer; accepted only while the model is in S_LOAD.
    task automatic load_beat(input logic [31:0] data, input logic last);
        check("load_ready", {31'b0, load_ready}, {31'b0, !model_run});
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        if (!model_run) begin
            model_mem[model_ptr] = data;
            if (last || model_ptr == DEPTH - 1) model_run = 1'b1;
            model_ptr = (model_ptr + 1) % DEPTH;
        end
        @(posedge clk);
        #1;
        idle_inputs();
        check("mem_ready", {31'b0, mem_ready}, {31'b0, model_run});
    endtask

    // One CPU cycle: read one address, optionally write another.
    task automatic cpu_cycle(input logic [31:0] ra, input logic [31:0] wa,
                             input logic [31:0] wd, input logic we);
        logic [31:0] exp;
        logic [31:0] got_exp;
        exp = 32'd0;
        if (model_run) begin
            if (in_range(ra)) exp = model_mem[ra[7:0]];
            if (we) begin
                if (in_range(wa)) begin
`ifdef MAIN_MEMORY_FORWARD_EN
                    if (in_range(ra) && ra == wa) exp = wd;
`endif
                    model_mem[wa[7:0]] = wd;
                end else begin
                    model_fault = 1'b1;
                end
            end
        end
        exp_q.push_back(exp);
        read_address  = ra;
        write_address = wa;
        write_data    = wd;
        write_enable  = we;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        got_exp = exp_q.pop_front();
        check($sformatf("read[%h]", ra), read_data, got_exp);
        check("fault", {31'b0, fault}, {31'b0, model_fault});
    endtask

    task automatic read_word(input logic [31:0] ra);
        cpu_cycle(ra, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        read_address  = '0;
        write_address = '0;
        write_data    = '0;
        load_data     = '0;
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_run   = 1'b0;
        model_ptr   = 0;
        model_fault = 1'b0;
        @(posedge clk);
        #1;

        // Basic boot load and readback.
        do_reset();
        load_beat(32'h11, 1'b0);
        load_beat(32'h22, 1'b0);
        load_beat(32'h33, 1'b0);
        load_beat(32'h44, 1'b1);
        check("load_ready_after", {31'b0, load_ready}, 32'd0);
        for (int a = 0; a < 4; a++) read_word(32'(a));

        // Same-index read during write, then a plain read of the new value.
        cpu_cycle(32'd2, 32'd2, 32'hDEADBEEF, 1'b1);
        read_word(32'd2);

        // Out-of-range write: dropped, sticky fault, OOR read returns 0.
        cpu_cycle(32'h100, 32'h100, 32'hBAD0BAD0, 1'b1);
        read_word(32'd0);
        read_word(32'h100);
        cpu_cycle(32'd3, 32'd1, 32'h5555AAAA, 1'b1);
        read_word(32'd1);
        read_word(32'h8000_0001);

        // Reset in S_RUN: contents kept, CPU writes ignored while loading.
        do_reset();
        cpu_cycle(32'd3, 32'd3, 32'h12345678, 1'b1);
        cpu_cycle(32'd1, 32'h100, 32'h0, 1'b1);
        load_beat(32'h77, 1'b1);
        for (int a = 0; a < 4; a++) read_word(32'(a));

        // Reset part way through a load restarts from word 0.
        do_reset();
        load_beat(32'hC1, 1'b0);
        load_beat(32'hC2, 1'b0);
        do_reset();
        load_beat(32'hA0, 1'b0);
        load_beat(32'hB0, 1'b1);
        for (int a = 0; a < 4; a++) read_word(32'(a));

        // Full-memory image without load_last: auto transition, extra beat ignored.
        do_reset();
        for (int i = 0; i < DEPTH; i++) load_beat(32'(i * 3 + 5), 1'b0);
        load_beat(32'hFFFF_FFFF, 1'b1);
        read_word(32'd0);
        read_word(32'd1);
        read_word(32'(DEPTH - 1));

        // Random mixed traffic, including occasional out-of-range addresses.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra, wa;
            ra = ($urandom_range(0, 15) == 0) ? 32'h100 + $urandom_range(0, 7) : 32'($urandom_range(0, 7));
            wa = ($urandom_range(0, 15) == 0) ? 32'h200 + $urandom_range(0, 7) : 32'($urandom_range(0, 7));
            cpu_cycle(ra, wa, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
